// File: rtl/siso_sched.sv
// Turbo-decoder SISO scheduler: sequences forward/backward trellis sweeps for
// both half-iterations and tracks the 2-cycle extrinsic output pipeline.
module siso_sched #(
  parameter int ADDR_W = 13,
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic [ITER_W-1:0] num_iter,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              half_idx,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              alpha_init,
  output logic              alpha_en,
  output logic              alpha_we,
  output logic [ADDR_W-1:0] alpha_waddr,
  output logic              beta_init,
  output logic              beta_en,
  output logic [ADDR_W-1:0] alpha_raddr,
  output logic              ext_vld,
  output logic [ADDR_W-1:0] ext_addr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    BWD   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] t_r;
  logic [ADDR_W-1:0] t_s;
  logic [ADDR_W-1:0] k_r;
  logic [ADDR_W-1:0] k_last_s;
  logic [ITER_W-1:0] n_r;
  logic [ITER_W-1:0] iter_s;
  logic              half_s;
  logic              drain_r;
  logic              drain_s;
  logic              accept_s;
  logic              reject_s;
  logic              flush_s;
  logic              pipe_vld_r;
  logic [ADDR_W-1:0] pipe_addr_r;

  assign k_last_s = k_r - ADDR_W'(1);

  // Next-state, step counter and iteration bookkeeping.
  always_comb begin
    state_s  = state_r;
    t_s      = t_r;
    iter_s   = iter_cnt;
    half_s   = half_idx;
    drain_s  = drain_r;
    accept_s = 1'b0;
    reject_s = 1'b0;
    flush_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((frame_len >= ADDR_W'(2)) && (num_iter != ITER_W'(0))) begin
            accept_s = 1'b1;
            state_s  = FWD;
            t_s      = ADDR_W'(0);
            iter_s   = ITER_W'(0);
            half_s   = 1'b0;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FWD: begin
        if (abort) begin
          flush_s = 1'b1;
          state_s = IDLE;
          t_s     = ADDR_W'(0);
        end else if (t_r == k_last_s) begin
          state_s = BWD;
        end else begin
          t_s = t_r + ADDR_W'(1);
        end
      end
      BWD: begin
        if (abort) begin
          flush_s = 1'b1;
          state_s = IDLE;
          t_s     = ADDR_W'(0);
        end else if (t_r == ADDR_W'(0)) begin
          state_s = DRAIN;
          drain_s = 1'b0;
        end else begin
          t_s = t_r - ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          flush_s = 1'b1;
          state_s = IDLE;
          t_s     = ADDR_W'(0);
        end else if (!drain_r) begin
          drain_s = 1'b1;
        end else if (!half_idx) begin
          half_s  = 1'b1;
          state_s = FWD;
          t_s     = ADDR_W'(0);
        end else if (iter_cnt < (n_r - ITER_W'(1))) begin
          iter_s  = iter_cnt + ITER_W'(1);
          half_s  = 1'b0;
          state_s = FWD;
          t_s     = ADDR_W'(0);
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        t_s     = ADDR_W'(0);
      end
    endcase
  end

  // State registers; outputs are registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      t_r         <= ADDR_W'(0);
      k_r         <= ADDR_W'(0);
      n_r         <= ITER_W'(0);
      drain_r     <= 1'b0;
      iter_cnt    <= ITER_W'(0);
      half_idx    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      alpha_init  <= 1'b0;
      alpha_en    <= 1'b0;
      alpha_we    <= 1'b0;
      alpha_waddr <= ADDR_W'(0);
      beta_init   <= 1'b0;
      beta_en     <= 1'b0;
      alpha_raddr <= ADDR_W'(0);
      pipe_vld_r  <= 1'b0;
      pipe_addr_r <= ADDR_W'(0);
      ext_vld     <= 1'b0;
      ext_addr    <= ADDR_W'(0);
    end else begin
      state_r  <= state_s;
      t_r      <= t_s;
      drain_r  <= drain_s;
      iter_cnt <= iter_s;
      half_idx <= half_s;
      if (accept_s) begin
        k_r <= frame_len;
        n_r <= num_iter;
      end
      busy        <= (state_s == FWD) || (state_s == BWD) || (state_s == DRAIN);
      done        <= (state_s == DONE);
      cfg_err     <= reject_s;
      alpha_en    <= (state_s == FWD);
      alpha_we    <= (state_s == FWD);
      alpha_init  <= (state_s == FWD) && (t_s == ADDR_W'(0));
      alpha_waddr <= (state_s == FWD) ? t_s : ADDR_W'(0);
      beta_en     <= (state_s == BWD);
      beta_init   <= (state_s == BWD) && (t_s == k_last_s);
      alpha_raddr <= (state_s == BWD) ? t_s : ADDR_W'(0);
      // Extrinsic valid trails the read strobe by memory latency plus adder stage.
      if (flush_s) begin
        pipe_vld_r  <= 1'b0;
        pipe_addr_r <= ADDR_W'(0);
        ext_vld     <= 1'b0;
        ext_addr    <= ADDR_W'(0);
      end else begin
        pipe_vld_r  <= beta_en;
        pipe_addr_r <= alpha_raddr;
        ext_vld     <= pipe_vld_r;
        ext_addr    <= pipe_addr_r;
      end
    end
  end

endmodule

// File: tb/tb_siso_sched.sv
// Self-checking bench for siso_sched: directed scenarios plus randomized
// decodes compared cycle by cycle against an arithmetic timeline model.
module tb_siso_sched;

  localparam int AW = 13;
  localparam int IW = 4;

  typedef logic [52:0] vec_t;
  localparam vec_t FULL    = '1;
  localparam vec_t NO_HI   = ~(53'h1F << 45);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] frame_len;
  logic [IW-1:0] num_iter;
  logic          abort;
  logic          busy, done, cfg_err, half_idx;
  logic [IW-1:0] iter_cnt;
  logic          alpha_init, alpha_en, alpha_we, beta_init, beta_en, ext_vld;
  logic [AW-1:0] alpha_waddr, alpha_raddr, ext_addr;
  vec_t          obs;

  int checks = 0;
  int errors = 0;

  siso_sched #(.ADDR_W(AW), .ITER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .num_iter(num_iter), .abort(abort), .busy(busy), .done(done),
    .cfg_err(cfg_err), .half_idx(half_idx), .iter_cnt(iter_cnt),
    .alpha_init(alpha_init), .alpha_en(alpha_en), .alpha_we(alpha_we),
    .alpha_waddr(alpha_waddr), .beta_init(beta_init), .beta_en(beta_en),
    .alpha_raddr(alpha_raddr), .ext_vld(ext_vld), .ext_addr(ext_addr)
  );

  assign obs = {cfg_err, busy, done, half_idx, iter_cnt, alpha_init, alpha_en,
                alpha_we, alpha_waddr, beta_init, beta_en, alpha_raddr,
                ext_vld, ext_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t pack(bit cf, bit bs, bit dn, bit hf, int it, bit ai,
                                bit ae, int aw, bit bi, bit be, int ar, bit ev,
                                int ea);
    return {cf, bs, dn, hf, IW'(it), ai, ae, ae, AW'(aw), bi, be, AW'(ar), ev, AW'(ea)};
  endfunction

  // Expected outputs c cycles after a decode start with K=k, N=n.
  function automatic vec_t model(int k, int n, int c);
    int l, dn, h, o;
    bit ai, ae, bi, be, ev;
    int aw, ar, ea;
    l  = 2 * k + 2;
    dn = 2 * n * l + 1;
    ai = 0; ae = 0; bi = 0; be = 0; ev = 0; aw = 0; ar = 0; ea = 0;
    if (c >= 1 && c < dn) begin
      h = (c - 1) / l;
      o = (c - 1) % l;
      if (o < k) begin
        ae = 1; aw = o; ai = (o == 0);
      end else if (o < 2 * k) begin
        be = 1; ar = 2 * k - 1 - o; bi = (o == k);
      end
      if (o >= k + 2) begin
        ev = 1; ea = 2 * k + 1 - o;
      end
      return pack(0, 1, 0, h[0], h / 2, ai, ae, aw, bi, be, ar, ev, ea);
    end else if (c == dn) begin
      return pack(0, 0, 1, 1, n - 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    return '0;
  endfunction

  task automatic check(string tag, vec_t got, vec_t exp, vec_t mask);
    checks++;
    assert ((got & mask) === (exp & mask))
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got & mask, exp & mask);
    end
  endtask

  task automatic run_decode(int k, int n, int abort_at, bit hold, bit scribble);
    int dn, last, evcnt;
    vec_t exp, mask;
    dn    = 2 * n * (2 * k + 2) + 1;
    last  = (abort_at != 0) ? abort_at + 2 : (hold ? dn + 2 : dn + 1);
    evcnt = 0;
    @(posedge clk); #1;
    start = 1'b1; frame_len = AW'(k); num_iter = IW'(n);
    abort = 1'($urandom_range(0, 1));
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      start = hold;
      abort = (c == abort_at);
      if (scribble) begin
        frame_len = AW'($urandom);
        num_iter  = IW'($urandom);
      end
      @(negedge clk);
      mask = (c > dn) ? NO_HI : FULL;
      if (abort_at != 0 && c > abort_at) begin
        exp = '0; mask = NO_HI;
      end else if (hold && c > dn + 1) begin
        exp = model(k, n, c - dn - 1); mask = FULL;
      end else begin
        exp = model(k, n, c);
      end
      check($sformatf("k%0d_n%0d_c%0d", k, n, c), obs, exp, mask);
      if (ext_vld && c <= dn) evcnt++;
    end
    start = 1'b0; abort = 1'b0;
    if (abort_at == 0 && !hold) begin
      checks++;
      assert (evcnt === 2 * n * k)
      else begin
        errors++;
        $error("FAIL ext_count observed=%0d expected=%0d", evcnt, 2 * n * k);
      end
    end
    if (hold) begin
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      check("hold_cleanup", obs, '0, NO_HI);
    end
  endtask

  task automatic cfg_reject(int k, int n);
    @(posedge clk); #1;
    start = 1'b1; frame_len = AW'(k); num_iter = IW'(n);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check($sformatf("cfg_err_k%0d_n%0d", k, n), obs,
          pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), NO_HI);
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("cfg_idle_k%0d_n%0d", k, n), obs, '0, NO_HI);
  endtask

  initial begin
    int k, n, ab;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    frame_len = AW'(0); num_iter = IW'(0);
    #2;
    check("reset_state", obs, '0, FULL);
    @(negedge clk); rst_n = 1'b1;

    run_decode(4, 1, 0, 0, 0);
    run_decode(4, 3, 0, 0, 1);
    run_decode(4, 1, 6, 0, 0);
    run_decode(3, 2, 0, 0, 0);
    cfg_reject(1, 2);
    cfg_reject(0, 1);
    cfg_reject(5, 0);

    // Asynchronous reset in the middle of a forward sweep.
    @(posedge clk); #1;
    start = 1'b1; frame_len = AW'(5); num_iter = IW'(2);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    check("async_reset", obs, '0, FULL);
    @(negedge clk); rst_n = 1'b1;
    run_decode(2, 1, 0, 0, 0);

    run_decode(3, 1, 0, 1, 0);

    for (int i = 0; i < 6; i++) begin
      k  = $urandom_range(2, 6);
      n  = $urandom_range(1, 3);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * n * (2 * k + 2)) : 0;
      run_decode(k, n, ab, 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
